mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of SRAM access cycles per transfer; legal range 1..15.
REQ-002 Parameter SRAM_AW, default 20, SRAM word-address width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 memOp_i  input  4  memory operation from the MEM stage, encoded per the cpu_mem_pkg memory-op codes.
REQ-006 virtualAddr_i  input  32  byte address of the access.
REQ-007 storeData_i  input  32  unaligned store operand; the low byte or halfword is significant for SB/SH.
REQ-008 loadData_o  output  32  aligned, extended load result.
REQ-009 pauseRequest_o  output  1  pipeline hold request.
REQ-010 misalign_o  output  1  misaligned-access flag, one cycle.
REQ-011 sram_addr_o  output  SRAM_AW  word address, virtualAddr[SRAM_AW+1:2].
REQ-012 sram_data_o  output  32  write data, lane-replicated.
REQ-013 sram_data_i  input  32  read data.
REQ-014 sram_be_n_o  output  4  byte enables, active-low.
REQ-015 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  output  1 each  chip, output and write strobes, active-low.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-017 IDLE: if memOp_i is not NOP and the access is legal, latch the op, address, lane-aligned data and byte enables, clear the wait counter, and go to ACCESS.
REQ-018 ACCESS: drive ce_n=0; loads drive oe_n=0, we_n=1; stores drive we_n=0, oe_n=1; the counter increments each cycle.
REQ-019 At counter==WAIT_CYCLES-1, ACCESS SHALL capture sram_data_i (loads only) into loadData_o and go to DONE; the access therefore lasts exactly WAIT_CYCLES cycles.
REQ-020 DONE: all strobes high, pauseRequest_o=0, loadData_o held; unconditionally return to IDLE. This prevents re-issue of the same op while the pipeline advances.
REQ-021 pauseRequest_o SHALL be combinational: 1 when in IDLE with a legal non-NOP op, and 1 throughout ACCESS; otherwise 0.
REQ-022 Resulting timing: accept in cycle 0; pause high for cycles 0..WAIT_CYCLES; result valid in cycle WAIT_CYCLES+1.
REQ-023 Store lanes: SB be=1<<addr[1:0] with the byte replicated x4; SH be=addr[1]?1100:0011 with the halfword replicated x2; SW be=1111. sram_be_n_o is the inverse.
REQ-024 Loads SHALL read all four lanes (be_n=0000); LB/LH sign-extend the selected lane, LBU/LHU zero-extend it, and LW passes the word through.
REQ-025 memOp_i changes during ACCESS SHALL be ignored because the latched copy is used.
REQ-026 loadData_o SHALL hold its value until the next completed load; stores do not modify it.

Reset
REQ-027 When rst=0 the block SHALL immediately enter IDLE, clear the counter, and drive loadData_o=0, all strobes and be_n to 1, sram_addr_o=0, sram_data_o=0 and misalign_o=0.
REQ-028 A reset during ACCESS SHALL abort the access with no completion pulse; after release the block returns to IDLE.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN controls alignment checking.
REQ-030 With MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, are illegal; misalign_o=1 combinationally in IDLE, no SRAM access occurs, pauseRequest_o=0 and loadData_o is unchanged.
REQ-031 With MEM_ALIGN_CHECK_EN undefined: misalign_o is tied 0; halfword ops ignore addr[0] and word ops ignore addr[1:0]; every non-NOP op is legal.

Structure
REQ-032 Package cpu_mem_pkg SHALL hold the memory-op codes (NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8) and the FSM state encoding.
REQ-033 Sub-module mem_lane_align SHALL contain the combinational byte-enable, store-replication and load-extension logic; the FSM stays in mem_bus_ctrl.

Verification
REQ-034 LW at 0x0000_0010, WAIT_CYCLES=2 -> sram_addr_o=0x4 and pause high for 3 cycles; sram_data_i=0xDEADBEEF gives loadData_o=0xDEADBEEF in cycle 3.
REQ-035 LB at 0x13 with sram_data_i=0x80FF_FFFF -> loadData_o=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-036 SH at 0x2 with storeData_i=0x1234_ABCD -> be_n=0011, sram_data_o=0xABCD_ABCD and we_n low for exactly 2 cycles.
REQ-037 With MEM_ALIGN_CHECK_EN defined, LW at 0x1 -> misalign_o=1, ce_n stays 1 and pause stays 0; with it undefined, the same op reads word 0x0.
REQ-038 Drive rst=0 in the second ACCESS cycle of an SW -> strobes go high asynchronously; after release, pause=0 and no write completes.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Memory-op codes, bus FSM state encoding and op classification helpers
// shared by the memory bus controller and its lane-alignment logic.
package cpu_mem_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// plus load lane selection with sign/zero extension.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  mem_op_e     st_op,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  mem_op_e     ld_op,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_op)
            OP_SB: begin
                st_be    = 4'b0001 << st_addr;
                st_wdata = {4{st_data[7:0]}};
            end
            OP_SH: begin
                st_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            // loads read every lane; the selected lane is extracted later
            OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        ld_byte = ld_raw[{ld_addr, 3'b000} +: 8];
        ld_half = ld_addr[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (ld_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h000000, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0000, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage to asynchronous SRAM bus controller with pipeline hold.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a legal non-NOP op; accepts it this cycle
// ST_ACCESS | SRAM strobes active for WAIT_CYCLES cycles
// ST_DONE   | strobes released, result valid, pipeline allowed to advance
module mem_bus_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         memOp_i,
    input  logic [31:0]        virtualAddr_i,
    input  logic [31:0]        storeData_i,
    output logic [31:0]        loadData_o,
    output logic               pauseRequest_o,
    output logic               misalign_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_data_o,
    input  logic [31:0]        sram_data_i,
    output logic [3:0]         sram_be_n_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    bus_state_e  state;
    logic [3:0]  cnt;
    mem_op_e     op_q;
    logic [1:0]  addr_lo_q;
    mem_op_e     op_in;
    logic        req;
    logic        bad_align;
    logic        accept;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        unused_addr_hi;

    assign op_in          = mem_op_e'(memOp_i);
    assign req            = (op_in != OP_NOP);
    assign unused_addr_hi = ^virtualAddr_i[31:SRAM_AW+2];

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align = is_misaligned(op_in, virtualAddr_i[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    assign accept         = rst && (state == ST_IDLE) && req && !bad_align;
    assign pauseRequest_o = accept || (state == ST_ACCESS);
    assign misalign_o     = rst && (state == ST_IDLE) && req && bad_align;

    mem_lane_align u_lane (
        .st_op    (op_in),
        .st_addr  (virtualAddr_i[1:0]),
        .st_data  (storeData_i),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_op    (op_q),
        .ld_addr  (addr_lo_q),
        .ld_raw   (sram_data_i),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            op_q        <= OP_NOP;
            addr_lo_q   <= 2'b00;
            loadData_o  <= 32'h0;
            sram_addr_o <= '0;
            sram_data_o <= 32'h0;
            sram_be_n_o <= 4'hF;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= op_in;
                        addr_lo_q   <= virtualAddr_i[1:0];
                        sram_addr_o <= virtualAddr_i[SRAM_AW+1:2];
                        sram_data_o <= st_wdata;
                        sram_be_n_o <= ~st_be;
                        cnt         <= 4'd0;
                        sram_ce_n_o <= 1'b0;
                        if (is_load(op_in)) sram_oe_n_o <= 1'b0;
                        else                sram_we_n_o <= 1'b0;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        if (is_load(op_q)) loadData_o <= ld_data;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl (default WAIT_CYCLES=2).
module tb_mem_bus_ctrl;
    import cpu_mem_pkg::*;

    localparam int W  = 2;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    memOp_i = 4'd0;
    logic [31:0]   virtualAddr_i = 32'h0;
    logic [31:0]   storeData_i = 32'h0;
    logic [31:0]   loadData_o;
    logic          pauseRequest_o;
    logic          misalign_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_data_o;
    logic [31:0]   sram_data_i = 32'h0;
    logic [3:0]    sram_be_n_o;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;

    int n_checks = 0;
    int n_err    = 0;
    int pcnt, ccnt, ocnt, wcnt;
    logic          mis0;
    logic          done;
    logic [AW-1:0] a_s;
    logic [3:0]    be_s;
    logic [31:0]   d_s;

    mem_bus_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .memOp_i        (memOp_i),
        .virtualAddr_i  (virtualAddr_i),
        .storeData_i    (storeData_i),
        .loadData_o     (loadData_o),
        .pauseRequest_o (pauseRequest_o),
        .misalign_o     (misalign_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_be_n_o    (sram_be_n_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one op in IDLE, then follows it until the pause drops
    // (DONE state, or immediately for a rejected op). Returns on that negedge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd);
        @(negedge clk);
        memOp_i = op; virtualAddr_i = addr; storeData_i = sd; sram_data_i = rd;
        pcnt = 0; ccnt = 0; ocnt = 0; wcnt = 0; done = 1'b0;
        #1;
        mis0 = misalign_o;
        if (pauseRequest_o) pcnt++;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a_s = sram_addr_o; be_s = sram_be_n_o; d_s = sram_data_o;
            end
            if (pauseRequest_o) pcnt++;
            if (!sram_ce_n_o) ccnt++;
            if (!sram_oe_n_o) ocnt++;
            if (!sram_we_n_o) wcnt++;
            if (!pauseRequest_o) done = 1'b1;
            else memOp_i = 4'd6;
        end
        memOp_i = 4'd0;
        chk("op_finished", 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_load",  loadData_o, 32'h0);
        chk("rst_addr",  32'(sram_addr_o), 32'h0);
        chk("rst_data",  sram_data_o, 32'h0);
        chk("rst_be_n",  32'(sram_be_n_o), 32'hF);
        chk("rst_ce_n",  32'(sram_ce_n_o), 32'd1);
        chk("rst_oe_n",  32'(sram_oe_n_o), 32'd1);
        chk("rst_we_n",  32'(sram_we_n_o), 32'd1);
        chk("rst_mis",   32'(misalign_o), 32'd0);
        chk("rst_pause", 32'(pauseRequest_o), 32'd0);
        rst = 1'b1;

        run_op(4'(OP_LW), 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        chk("lw_pause_cycles", 32'(pcnt), 32'(W + 1));
        chk("lw_ce_cycles",    32'(ccnt), 32'(W));
        chk("lw_oe_cycles",    32'(ocnt), 32'(W));
        chk("lw_we_cycles",    32'(wcnt), 32'd0);
        chk("lw_addr",         32'(a_s), 32'h4);
        chk("lw_be_n",         32'(be_s), 32'h0);
        chk("lw_data",         loadData_o, 32'hDEAD_BEEF);

        run_op(4'(OP_LB), 32'h0000_0013, 32'h0, 32'h80FF_FFFF);
        chk("lb_addr", 32'(a_s), 32'h4);
        chk("lb_data", loadData_o, 32'hFFFF_FF80);

        run_op(4'(OP_LBU), 32'h0000_0013, 32'h0, 32'h80FF_FFFF);
        chk("lbu_data", loadData_o, 32'h0000_0080);

        run_op(4'(OP_SH), 32'h0000_0002, 32'h1234_ABCD, 32'h5555_5555);
        chk("sh_be_n",      32'(be_s), 32'h3);
        chk("sh_wdata",     d_s, 32'hABCD_ABCD);
        chk("sh_we_cycles", 32'(wcnt), 32'(W));
        chk("sh_oe_cycles", 32'(ocnt), 32'd0);
        chk("sh_load_held", loadData_o, 32'h0000_0080);

        run_op(4'(OP_SB), 32'h0000_0001, 32'h0000_00A5, 32'h0);
        chk("sb_be_n",  32'(be_s), 32'hD);
        chk("sb_wdata", d_s, 32'hA5A5_A5A5);

        run_op(4'(OP_SW), 32'h0000_0104, 32'h1122_3344, 32'h0);
        chk("sw_be_n",  32'(be_s), 32'h0);
        chk("sw_wdata", d_s, 32'h1122_3344);
        chk("sw_addr",  32'(a_s), 32'h41);

        run_op(4'(OP_LH), 32'h0000_0006, 32'h0, 32'h8001_7FFF);
        chk("lh_data", loadData_o, 32'hFFFF_8001);

        run_op(4'(OP_LHU), 32'h0000_0004, 32'h0, 32'h8001_F00D);
        chk("lhu_data", loadData_o, 32'h0000_F00D);

        run_op(4'(OP_LW), 32'h0000_0001, 32'h0, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHECK_EN
        chk("lw1_misalign", 32'(mis0), 32'd1);
        chk("lw1_pause",    32'(pcnt), 32'd0);
        chk("lw1_ce",       32'(ccnt), 32'd0);
        chk("lw1_load",     loadData_o, 32'h0000_F00D);
`else
        chk("lw1_misalign", 32'(mis0), 32'd0);
        chk("lw1_pause",    32'(pcnt), 32'(W + 1));
        chk("lw1_addr",     32'(a_s), 32'h0);
        chk("lw1_load",     loadData_o, 32'hCAFE_F00D);
`endif

        // reset in the second ACCESS cycle of a store
        @(negedge clk);
        memOp_i = 4'(OP_SW); virtualAddr_i = 32'h20; storeData_i = 32'h55AA_55AA;
        @(negedge clk);
        memOp_i = 4'd0;
        chk("abort_we_active", 32'(sram_we_n_o), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ce_n",  32'(sram_ce_n_o), 32'd1);
        chk("abort_we_n",  32'(sram_we_n_o), 32'd1);
        chk("abort_be_n",  32'(sram_be_n_o), 32'hF);
        chk("abort_pause", 32'(pauseRequest_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wcnt = 0; pcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (!sram_we_n_o) wcnt++;
            if (pauseRequest_o) pcnt++;
        end
        chk("abort_no_write", 32'(wcnt), 32'd0);
        chk("abort_no_pause", 32'(pcnt), 32'd0);
        chk("abort_load_clr", loadData_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
